fpmul_rr_sched: RTL and testbench

//  Round-robin scheduler sharing one multi-cycle single-precision FP multiplier
//  (registered operand stage + 25-step Booth core) between NREQ requesters.

---
 rtl/fpmul_rr_sched.sv | 150 +++++++++++++++
 tb/tb_fpmul_rr_sched.sv | 276 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpmul_rr_sched.sv
// fpmul_rr_sched: round-robin scheduler that shares one multi-cycle FP
// multiplier core between NREQ requesters. It picks a winner, freezes its
// operands, walks the core through clear/load/run, and returns the product
// tagged with the winner's ID.
module fpmul_rr_sched #(
    parameter int NREQ     = 4,
    parameter int IDW      = 2,
    parameter int LOAD_CYC = 2,
    parameter int MUL_LAT  = 28
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic [NREQ-1:0]     i_req,
    input  logic [32*NREQ-1:0]  i_a,
    input  logic [32*NREQ-1:0]  i_b,
    output logic [NREQ-1:0]     o_gnt,
    output logic                o_mul_clr,
    output logic                o_mul_load,
    output logic [31:0]         o_mul_a,
    output logic [31:0]         o_mul_b,
    input  logic [31:0]         i_mul_res,
    output logic [31:0]         o_res,
    output logic                o_res_valid,
    output logic [IDW-1:0]      o_res_id,
    output logic                o_busy
);

    localparam int CMAX = (LOAD_CYC > MUL_LAT) ? LOAD_CYC : MUL_LAT;
    localparam int CW   = $clog2(CMAX + 1);

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_LOAD,
        S_RUN,
        S_DONE
    } state_t;

    state_t           r_state;
    logic [IDW-1:0]   r_ptr;
    logic [IDW-1:0]   r_id;
    logic [CW-1:0]    r_cnt;

    logic [IDW-1:0]   w_sel;
    logic             w_any;
    logic [IDW-1:0]   w_ptrNext;
    logic [31:0]      w_opA;
    logic [31:0]      w_opB;

    // (base + off) mod NREQ, valid for off in 0..NREQ-1
    function automatic logic [IDW-1:0] wrapIdx(input logic [IDW-1:0] base, input int off);
        int s;
        s = int'(base) + off;
        if (s >= NREQ) begin
            s = s - NREQ;
        end
        return IDW'(s);
    endfunction

    // Round-robin pick: scan from the pointer upward; descending loop so the
    // smallest offset from the pointer is the last (winning) assignment.
    always_comb begin
        w_sel = '0;
        w_any = 1'b0;
        for (int i = NREQ - 1; i >= 0; i--) begin
            if (i_req[wrapIdx(r_ptr, i)]) begin
                w_sel = wrapIdx(r_ptr, i);
                w_any = 1'b1;
            end
        end
    end

    assign w_ptrNext = wrapIdx(r_id, 1);
    assign w_opA     = i_a[{w_sel, 5'b0} +: 32];
    assign w_opB     = i_b[{w_sel, 5'b0} +: 32];

    // Scheduler FSM; every output is a register updated on the way into a state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_ptr       <= '0;
            r_id        <= '0;
            r_cnt       <= '0;
            o_gnt       <= '0;
            o_mul_clr   <= 1'b1;
            o_mul_load  <= 1'b0;
            o_mul_a     <= '0;
            o_mul_b     <= '0;
            o_res       <= '0;
            o_res_valid <= 1'b0;
            o_res_id    <= '0;
            o_busy      <= 1'b0;
        end else begin
            o_gnt       <= '0;
            o_res_valid <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    o_mul_clr  <= 1'b0;
                    o_mul_load <= 1'b0;
                    if (w_any) begin
                        o_gnt     <= NREQ'(1) << w_sel;
                        o_mul_a   <= w_opA;
                        o_mul_b   <= w_opB;
                        r_id      <= w_sel;
                        o_mul_clr <= 1'b1;
                        o_busy    <= 1'b1;
                        r_state   <= S_CLR;
                    end else begin
                        o_busy <= 1'b0;
                    end
                end
                S_CLR: begin
                    o_mul_clr  <= 1'b0;
                    o_mul_load <= 1'b1;
                    r_cnt      <= CW'(LOAD_CYC - 1);
                    r_state    <= S_LOAD;
                end
                S_LOAD: begin
                    if (r_cnt == '0) begin
                        o_mul_load <= 1'b0;
                        r_cnt      <= CW'(MUL_LAT - 1);
                        r_state    <= S_RUN;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_RUN: begin
                    if (r_cnt == '0) begin
                        r_state <= S_DONE;
                    end else begin
                        r_cnt <= r_cnt - CW'(1);
                    end
                end
                S_DONE: begin
                    o_res       <= i_mul_res;
                    o_res_id    <= r_id;
                    o_res_valid <= 1'b1;
                    r_ptr       <= w_ptrNext;
                    o_busy      <= 1'b0;
                    r_state     <= S_IDLE;
                end
                default: begin
                    o_busy  <= 1'b0;
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fpmul_rr_sched.sv
// tb_fpmul_rr_sched: directed bench for the round-robin FP multiplier
// scheduler. A behavioural core stands in for the Booth multiplier and only
// presents a valid product MUL_LAT cycles after load drops.
module tb_fpmul_rr_sched;

    localparam int NREQ     = 4;
    localparam int IDW      = 2;
    localparam int LOAD_CYC = 2;
    localparam int MUL_LAT  = 28;
    localparam int LAT      = 1 + LOAD_CYC + MUL_LAT + 1;

    logic                i_clk = 1'b0;
    logic                i_rst;
    logic [NREQ-1:0]     i_req;
    logic [32*NREQ-1:0]  i_a;
    logic [32*NREQ-1:0]  i_b;
    logic [NREQ-1:0]     o_gnt;
    logic                o_mul_clr;
    logic                o_mul_load;
    logic [31:0]         o_mul_a;
    logic [31:0]         o_mul_b;
    logic [31:0]         i_mul_res;
    logic [31:0]         o_res;
    logic                o_res_valid;
    logic [IDW-1:0]      o_res_id;
    logic                o_busy;

    int checks   = 0;
    int failures = 0;

    logic [31:0] opA [NREQ];
    logic [31:0] opB [NREQ];

    typedef struct packed {
        logic [IDW-1:0] id;
        logic [31:0]    res;
    } sbEntry_t;

    sbEntry_t sb [$];

    fpmul_rr_sched #(
        .NREQ(NREQ), .IDW(IDW), .LOAD_CYC(LOAD_CYC), .MUL_LAT(MUL_LAT)
    ) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_req(i_req), .i_a(i_a), .i_b(i_b),
        .o_gnt(o_gnt), .o_mul_clr(o_mul_clr), .o_mul_load(o_mul_load),
        .o_mul_a(o_mul_a), .o_mul_b(o_mul_b), .i_mul_res(i_mul_res),
        .o_res(o_res), .o_res_valid(o_res_valid), .o_res_id(o_res_id),
        .o_busy(o_busy)
    );

    // Free-running clock
    always #5 i_clk = ~i_clk;

    // Products the stand-in core returns; known IEEE cases plus a scramble
    function automatic logic [31:0] coreModel(input logic [31:0] a, input logic [31:0] b);
        case ({a, b})
            {32'h40000000, 32'h40400000}: return 32'h40C00000;
            {32'h7F800000, 32'h00000000}: return 32'hFFFFFFFF;
            {32'h00000001, 32'h3F800000}: return 32'h00000001;
            {32'h7F000000, 32'h7F000000}: return 32'h7F800000;
            default:                      return a ^ {b[15:0], b[31:16]} ^ 32'h13579BDF;
        endcase
    endfunction

    logic [31:0] coreA;
    logic [31:0] coreB;
    int          coreCnt;
    logic        coreArmed;

    // Stand-in multiplier core: clear re-arms, load captures, then counts
    always @(posedge i_clk) begin
        if (o_mul_clr) begin
            coreCnt   <= 0;
            coreArmed <= 1'b0;
        end else if (o_mul_load) begin
            coreA     <= o_mul_a;
            coreB     <= o_mul_b;
            coreCnt   <= 0;
            coreArmed <= 1'b1;
        end else if (coreArmed && coreCnt < MUL_LAT) begin
            coreCnt <= coreCnt + 1;
        end
    end

    assign i_mul_res = (coreArmed && coreCnt >= MUL_LAT) ? coreModel(coreA, coreB) : 32'hDEADBEEF;

    // Hard stop in case something hangs outside a bounded wait
    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired");
        $fatal(1, "[TB] watchdog");
    end

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input int k, input logic [31:0] a, input logic [31:0] b);
        opA[k]            = a;
        opB[k]            = b;
        i_a[32*k +: 32]   = a;
        i_b[32*k +: 32]   = b;
    endtask

    // One full operation: wait for grant, queue the expected result, watch the
    // core controls while busy, then compare the returned product and tag.
    task automatic doOp(input int expId, input bit keepReq, input string tag);
        int          cyc;
        int          lat;
        int          clrCnt;
        int          loadCnt;
        int          busyLow;
        int          opMoves;
        int          gntExtra;
        logic [31:0] expA;
        logic [31:0] expB;
        sbEntry_t    e;
        cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
        end while (o_gnt == '0 && cyc < 100);
        checkOutput({tag, ".gnt"}, 32'(o_gnt), 32'(1) << expId);
        if (o_gnt == '0) return;
        expA = opA[expId];
        expB = opB[expId];
        checkOutput({tag, ".mulA"}, o_mul_a, expA);
        checkOutput({tag, ".mulB"}, o_mul_b, expB);
        e.id  = IDW'(expId);
        e.res = coreModel(expA, expB);
        sb.push_back(e);
        if (!keepReq) i_req[expId] = 1'b0;
        clrCnt   = o_mul_clr ? 1 : 0;
        loadCnt  = o_mul_load ? 1 : 0;
        busyLow  = o_busy ? 0 : 1;
        opMoves  = 0;
        gntExtra = 0;
        lat      = 0;
        while (!o_res_valid && lat < LAT + 20) begin
            i_a[32*expId +: 32] = $urandom;
            i_b[32*expId +: 32] = $urandom;
            @(negedge i_clk);
            lat++;
            if (!o_res_valid) begin
                if (o_mul_clr)  clrCnt++;
                if (o_mul_load) loadCnt++;
                if (!o_busy)    busyLow++;
                if (o_gnt != '0) gntExtra++;
            end
            if (o_mul_a !== expA || o_mul_b !== expB) opMoves++;
        end
        i_a[32*expId +: 32] = opA[expId];
        i_b[32*expId +: 32] = opB[expId];
        checkOutput({tag, ".latency"}, lat, LAT);
        checkOutput({tag, ".clrCycles"}, clrCnt, 1);
        checkOutput({tag, ".loadCycles"}, loadCnt, LOAD_CYC);
        checkOutput({tag, ".busyLow"}, busyLow, 0);
        checkOutput({tag, ".gntExtra"}, gntExtra, 0);
        checkOutput({tag, ".opMoves"}, opMoves, 0);
        checkOutput({tag, ".busyAtDone"}, 32'(o_busy), 0);
        e = sb.pop_front();
        checkOutput({tag, ".res"}, o_res, e.res);
        checkOutput({tag, ".id"}, 32'(o_res_id), 32'(e.id));
    endtask

    // Directed sequence
    initial begin
        int cyc;
        int validSeen;
        i_rst = 1'b1;
        i_req = '0;
        i_a   = '0;
        i_b   = '0;
        for (int k = 0; k < NREQ; k++) applyStimulus(k, 32'h0, 32'h0);
        repeat (3) @(negedge i_clk);
        checkOutput("rst.gnt", 32'(o_gnt), 0);
        checkOutput("rst.clr", 32'(o_mul_clr), 1);
        checkOutput("rst.load", 32'(o_mul_load), 0);
        checkOutput("rst.mulA", o_mul_a, 0);
        checkOutput("rst.mulB", o_mul_b, 0);
        checkOutput("rst.res", o_res, 0);
        checkOutput("rst.valid", 32'(o_res_valid), 0);
        checkOutput("rst.id", 32'(o_res_id), 0);
        checkOutput("rst.busy", 32'(o_busy), 0);
        i_rst = 1'b0;
        repeat (2) @(negedge i_clk);
        checkOutput("idle.gnt", 32'(o_gnt), 0);
        checkOutput("idle.clr", 32'(o_mul_clr), 0);
        checkOutput("idle.busy", 32'(o_busy), 0);

        $display("[TB] single request");
        applyStimulus(0, 32'h40000000, 32'h40400000);
        i_req = 4'b0001;
        doOp(0, 1'b0, "single");

        $display("[TB] all four requesting");
        i_rst = 1'b1;
        @(negedge i_clk);
        i_rst = 1'b0;
        for (int k = 0; k < NREQ; k++) begin
            applyStimulus(k, 32'h3F800000 + (32'(k) << 16), 32'hC0100000 + 32'(k * 3));
        end
        i_req = 4'b1111;
        for (int k = 0; k < NREQ; k++) doOp(k, 1'b0, "all");
        applyStimulus(0, 32'h41200000, 32'h3E800000);
        applyStimulus(3, 32'h42C80000, 32'hBF000000);
        i_req = 4'b1001;
        doOp(0, 1'b0, "wrap0");
        doOp(3, 1'b0, "wrap3");

        $display("[TB] held requester alternation");
        applyStimulus(2, 32'h40A00000, 32'h40E00000);
        applyStimulus(1, 32'h3FC00000, 32'h41000000);
        i_req = 4'b0100;
        doOp(2, 1'b1, "alt2a");
        i_req[1] = 1'b1;
        doOp(1, 1'b0, "alt1a");
        i_req[1] = 1'b1;
        doOp(2, 1'b1, "alt2b");
        i_req[1] = 1'b1;
        doOp(1, 1'b0, "alt1b");
        i_req[2] = 1'b0;

        $display("[TB] special operands");
        applyStimulus(1, 32'h7F800000, 32'h00000000);
        i_req = 4'b0010;
        doOp(1, 1'b0, "infZero");
        applyStimulus(1, 32'h00000001, 32'h3F800000);
        i_req = 4'b0010;
        doOp(1, 1'b0, "subnorm");
        applyStimulus(1, 32'h7F000000, 32'h7F000000);
        i_req = 4'b0010;
        doOp(1, 1'b0, "overflow");

        $display("[TB] reset during run");
        applyStimulus(3, 32'h40400000, 32'h40400000);
        i_req = 4'b1000;
        cyc = 0;
        do begin
            @(negedge i_clk);
            cyc++;
        end while (o_gnt == '0 && cyc < 100);
        checkOutput("abort.gnt", 32'(o_gnt), 32'h8);
        repeat (12) @(negedge i_clk);
        checkOutput("abort.busyInRun", 32'(o_busy), 1);
        checkOutput("abort.loadInRun", 32'(o_mul_load), 0);
        i_rst = 1'b1;
        @(negedge i_clk);
        checkOutput("abort.busy", 32'(o_busy), 0);
        checkOutput("abort.valid", 32'(o_res_valid), 0);
        checkOutput("abort.res", o_res, 0);
        checkOutput("abort.clr", 32'(o_mul_clr), 1);
        i_req = '0;
        @(negedge i_clk);
        i_rst = 1'b0;
        validSeen = 0;
        for (int c = 0; c < 45; c++) begin
            @(negedge i_clk);
            if (o_res_valid) validSeen++;
        end
        checkOutput("abort.noValid", validSeen, 0);
        applyStimulus(0, 32'hBF800000, 32'h40800000);
        i_req = 4'b1001;
        doOp(0, 1'b0, "postRst0");
        doOp(3, 1'b0, "postRst3");

        checkOutput("sb.empty", sb.size(), 0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
